// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage sitting directly after the execute stage.
// Non-memory instructions pass straight through to write-back in the same
// cycle. Loads and stores are serialised one byte per cycle over a byte-wide
// RAM port, little-endian, starting at the effective address and wrapping
// at ADDR_WIDTH bits. While an access is in flight stallreq_o holds the
// upstream pipeline, which keeps the instruction inputs stable.
//
// Parameters
//   ADDR_WIDTH  width of the RAM byte address (mem_a_o)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   op_i        opcode from execute (LOAD 7'b0000011, STORE 7'b0100011)
//   funct3_i    [1:0] size: 00 byte, 01 half, else word; [2] zero-extend
//   mem_addr_i  effective byte address
//   reg_i       store data, sent least-significant byte first
//   wd_i        destination register address
//   wreg_i      write-back enable
//   wdata_i     execute-stage result
//   mem_din_i   RAM read data, valid one cycle after the address
//   mem_a_o     RAM byte address
//   mem_dout_o  RAM write data
//   mem_wr_o    RAM write strobe (1 = write, 0 = read)
//   stallreq_o  stall request to the upstream pipeline
//   wd_o        write-back register address
//   wreg_o      write-back enable
//   wdata_o     write-back data
//
// Cycle budget: a load stalls for N+2 cycles (request, N address cycles,
// one cycle to catch the last returning byte), a store for N+1 cycles;
// both then spend one DONE cycle presenting the result to write-back.
// ----------------------------------------------------------------------------
module mem_stage #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            op_i,
   input  logic [2:0]            funct3_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           reg_i,
   input  logic [4:0]            wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic [7:0]            mem_din_i,
   output logic [ADDR_WIDTH-1:0] mem_a_o,
   output logic [7:0]            mem_dout_o,
   output logic                  mem_wr_o,
   output logic                  stallreq_o,
   output logic [4:0]            wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Index of the last byte of the access (N-1) for the given size code.
   function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
      logic [1:0] idx;
      case (size)
         2'b00:   idx = 2'd0;
         2'b01:   idx = 2'd1;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   // Sign- or zero-extend the assembled load bytes from 8N bits to 32.
   function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                               input logic [2:0]  f3);
      logic [31:0] res;
      case (f3[1:0])
         2'b00: begin
            if (f3[2]) begin
               res = {24'h000000, raw[7:0]};
            end else begin
               res = {{24{raw[7]}}, raw[7:0]};
            end
         end
         2'b01: begin
            if (f3[2]) begin
               res = {16'h0000, raw[15:0]};
            end else begin
               res = {{16{raw[15]}}, raw[15:0]};
            end
         end
         default: res = raw;
      endcase
      return res;
   endfunction

   state_t                 state_r;
   logic [1:0]             cnt_r;
   logic [31:0]            buf_r;

   logic                   is_load_s;
   logic                   is_store_s;
   logic                   is_mem_s;
   logic [1:0]             last_idx_s;
   logic [1:0]             prev_idx_s;
   logic [ADDR_WIDTH-1:0]  base_addr_s;
   logic                   unused_addr_bits_s;

   assign is_load_s   = (op_i == OP_LOAD);
   assign is_store_s  = (op_i == OP_STORE);
   assign is_mem_s    = is_load_s | is_store_s;
   assign last_idx_s  = last_byte_idx(funct3_i[1:0]);
   // Byte slot for data returning now: it was addressed one cycle ago.
   assign prev_idx_s  = cnt_r - 2'd1;
   // Upper address bits beyond the RAM port are dropped, so accesses wrap.
   assign base_addr_s = mem_addr_i[ADDR_WIDTH-1:0];
   assign unused_addr_bits_s = ^mem_addr_i[31:ADDR_WIDTH];

   // Access sequencer: state, byte counter and load assembly buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 2'd0;
         buf_r   <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= 2'd0;
               if (is_mem_s) begin
                  state_r <= ST_BUSY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               // Byte 0 has not returned yet on the first address cycle.
               if (is_load_s && (cnt_r != 2'd0)) begin
                  buf_r[{prev_idx_s, 3'b000} +: 8] <= mem_din_i;
               end
               if (cnt_r == last_idx_s) begin
                  cnt_r   <= 2'd0;
                  state_r <= is_load_s ? ST_FINAL : ST_DONE;
               end else begin
                  cnt_r   <= cnt_r + 2'd1;
                  state_r <= ST_BUSY;
               end
            end
            ST_FINAL: begin
               // Catch the byte addressed in the last BUSY cycle.
               buf_r[{last_idx_s, 3'b000} +: 8] <= mem_din_i;
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               // The pipeline advances on this edge; never restart.
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 2'd0;
            end
         endcase
      end
   end

   // Output decode; reset forces every output to its idle value at once.
   always_comb begin
      mem_a_o    = '0;
      mem_dout_o = 8'h00;
      mem_wr_o   = 1'b0;
      stallreq_o = 1'b0;
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'h0000_0000;
      if (rst) begin
         mem_wr_o   = 1'b0;
         stallreq_o = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (is_mem_s) begin
                  stallreq_o = 1'b1;
               end else begin
                  wd_o    = wd_i;
                  wreg_o  = wreg_i;
                  wdata_o = wdata_i;
               end
            end
            ST_BUSY: begin
               stallreq_o = 1'b1;
               mem_a_o    = base_addr_s + {{(ADDR_WIDTH-2){1'b0}}, cnt_r};
               if (is_store_s) begin
                  mem_wr_o   = 1'b1;
                  mem_dout_o = reg_i[{cnt_r, 3'b000} +: 8];
               end else begin
                  mem_wr_o   = 1'b0;
               end
            end
            ST_FINAL: begin
               stallreq_o = 1'b1;
            end
            ST_DONE: begin
               wd_o   = wd_i;
               wreg_o = wreg_i;
               if (is_load_s) begin
                  wdata_o = load_extend(buf_r, funct3_i);
               end else begin
                  wdata_o = wdata_i;
               end
            end
            default: begin
               stallreq_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. Each instruction pushes its expected
// write-back result (and expected stall length) onto one queue and its
// expected RAM writes onto another; an independent monitor on the falling
// edge pops and compares whenever the stage presents a write-back result
// (stallreq_o low) or strobes a RAM write. A byte RAM model with one-cycle
// read latency serves the port.
// ----------------------------------------------------------------------------
module tb_mem_stage;

   localparam int AW = 17;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic          clk;
   logic          rst;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic [31:0]   mem_addr;
   logic [31:0]   reg_v;
   logic [4:0]    wd;
   logic          wreg;
   logic [31:0]   wdata;
   logic [7:0]    mem_din;
   logic [AW-1:0] mem_a;
   logic [7:0]    mem_dout;
   logic          mem_wr;
   logic          stallreq;
   logic [4:0]    wd_out;
   logic          wreg_out;
   logic [31:0]   wdata_out;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      int          stall;
   } wb_exp_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_exp_t;

   wb_exp_t wb_q[$];
   wr_exp_t wr_q[$];

   int   n_checks;
   int   n_pass;
   logic mon_en;
   logic [7:0] ram [0:(1<<AW)-1];

   mem_stage #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .op_i       (op),
      .funct3_i   (funct3),
      .mem_addr_i (mem_addr),
      .reg_i      (reg_v),
      .wd_i       (wd),
      .wreg_i     (wreg),
      .wdata_i    (wdata),
      .mem_din_i  (mem_din),
      .mem_a_o    (mem_a),
      .mem_dout_o (mem_dout),
      .mem_wr_o   (mem_wr),
      .stallreq_o (stallreq),
      .wd_o       (wd_out),
      .wreg_o     (wreg_out),
      .wdata_o    (wdata_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM model: one-cycle registered read, write on strobe.
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
      ram[17'h00100] = 8'h78;
      ram[17'h00101] = 8'h56;
      ram[17'h00102] = 8'h34;
      ram[17'h00103] = 8'h12;
      ram[17'h00007] = 8'h80;
      mem_din = 8'h00;
      forever begin
         @(posedge clk);
         mem_din <= ram[mem_a];
         if (mem_wr) ram[mem_a] = mem_dout;
      end
   end

   // Monitor: compare write-back results and RAM writes against the queues.
   initial begin
      int      stall_cnt;
      wb_exp_t e;
      wr_exp_t w;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_cnt = 0;
         end else if (mon_en) begin
            if (mem_wr) begin
               if (wr_q.size() == 0) begin
                  n_checks = n_checks + 1;
                  $display("FAIL ram_write: unexpected write %h@%h", mem_dout, mem_a);
               end else begin
                  w = wr_q.pop_front();
                  chk("ram_addr", 32'(mem_a), 32'(w.a));
                  chk("ram_data", 32'(mem_dout), 32'(w.d));
               end
            end
            if (stallreq) begin
               stall_cnt = stall_cnt + 1;
            end else begin
               if (wb_q.size() == 0) begin
                  n_checks = n_checks + 1;
                  $display("FAIL wb: unexpected result %h", wdata_out);
               end else begin
                  e = wb_q.pop_front();
                  chk("wb_wd", 32'(wd_out), 32'(e.wd));
                  chk("wb_wreg", 32'(wreg_out), 32'(e.wreg));
                  chk("wb_wdata", wdata_out, e.wdata);
                  chk("stall_len", 32'(stall_cnt), 32'(e.stall));
               end
               stall_cnt = 0;
            end
         end
      end
   end

   task automatic drive(input logic [6:0] o, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] r,
                        input logic [4:0] d, input logic we,
                        input logic [31:0] wv);
      op = o; funct3 = f3; mem_addr = a; reg_v = r;
      wd = d; wreg = we; wdata = wv;
   endtask

   // Called just after a rising edge; returns just after the edge that
   // retires the instruction.
   task automatic issue(input logic [6:0] o, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] r,
                        input logic [4:0] d, input logic we,
                        input logic [31:0] wv, input int exp_stall,
                        input logic [31:0] exp_data, input logic exp_wreg);
      wb_exp_t e;
      bit      done;
      e.wd = d; e.wreg = exp_wreg; e.wdata = exp_data; e.stall = exp_stall;
      wb_q.push_back(e);
      drive(o, f3, a, r, d, we, wv);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!stallreq) done = 1'b1;
      end
      if (!done) begin
         n_checks = n_checks + 1;
         $display("FAIL timeout: stall still high after 20 cycles, op %b", o);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input logic [7:0] d);
      wr_exp_t w;
      w.a = a; w.d = d;
      wr_q.push_back(w);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      mon_en   = 1'b0;
      rst      = 1'b1;
      // Non-zero inputs during reset: outputs must still sit at reset values.
      drive(OP_R, 3'b000, 32'h0, 32'h0, 5'd7, 1'b1, 32'h5555_5555);
      #12;
      chk("rst_mem_a", 32'(mem_a), 32'h0);
      chk("rst_mem_dout", 32'(mem_dout), 32'h0);
      chk("rst_mem_wr", 32'(mem_wr), 32'h0);
      chk("rst_stall", 32'(stallreq), 32'h0);
      chk("rst_wd", 32'(wd_out), 32'h0);
      chk("rst_wreg", 32'(wreg_out), 32'h0);
      chk("rst_wdata", wdata_out, 32'h0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      issue(OP_R,     3'b000, 32'h0,     32'h0,    5'd5,  1'b1, 32'h1234,      0, 32'h0000_1234, 1'b1);
      issue(OP_LOAD,  3'b010, 32'h100,   32'h0,    5'd10, 1'b1, 32'hDEAD_0000, 6, 32'h1234_5678, 1'b1);
      issue(OP_LOAD,  3'b000, 32'h7,     32'h0,    5'd11, 1'b1, 32'h0,         3, 32'hFFFF_FF80, 1'b1);
      issue(OP_LOAD,  3'b100, 32'h7,     32'h0,    5'd12, 1'b1, 32'h0,         3, 32'h0000_0080, 1'b1);
      exp_wr(17'h1FFFF, 8'hEF);
      exp_wr(17'h00000, 8'hBE);
      issue(OP_STORE, 3'b001, 32'h1FFFF, 32'hBEEF, 5'd0, 1'b0, 32'h0001_FFFF, 3, 32'h0001_FFFF, 1'b0);
      issue(OP_LOAD,  3'b101, 32'h1FFFF, 32'h0,    5'd13, 1'b1, 32'h0,         4, 32'h0000_BEEF, 1'b1);
      issue(OP_LOAD,  3'b001, 32'h1FFFF, 32'h0,    5'd14, 1'b1, 32'h0,         4, 32'hFFFF_BEEF, 1'b1);
      // Load followed immediately by a register op.
      issue(OP_LOAD,  3'b010, 32'h100,   32'h0,    5'd15, 1'b1, 32'h0,         6, 32'h1234_5678, 1'b1);
      issue(OP_R,     3'b000, 32'h0,     32'h0,    5'd3,  1'b1, 32'hABCD,      0, 32'h0000_ABCD, 1'b1);

      // Store aborted by reset during its third byte cycle.
      exp_wr(17'h00200, 8'hAA);
      exp_wr(17'h00201, 8'hBB);
      drive(OP_STORE, 3'b010, 32'h200, 32'hDDCC_BBAA, 5'd0, 1'b0, 32'h200);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_mem_wr", 32'(mem_wr), 32'h0);
      chk("abort_stall", 32'(stallreq), 32'h0);
      chk("abort_mem_a", 32'(mem_a), 32'h0);
      chk("abort_wreg", 32'(wreg_out), 32'h0);
      chk("abort_wdata", wdata_out, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_wr(17'h00200, 8'hAA);
      exp_wr(17'h00201, 8'hBB);
      exp_wr(17'h00202, 8'hCC);
      exp_wr(17'h00203, 8'hDD);
      issue(OP_STORE, 3'b010, 32'h200, 32'hDDCC_BBAA, 5'd0, 1'b0, 32'h200,     5, 32'h0000_0200, 1'b0);
      // funct3 011 behaves as a word; unaligned word; positive byte.
      issue(OP_LOAD,  3'b011, 32'h200,   32'h0,    5'd16, 1'b1, 32'h0,         6, 32'hDDCC_BBAA, 1'b1);
      issue(OP_LOAD,  3'b010, 32'h201,   32'h0,    5'd17, 1'b1, 32'h0,         6, 32'h00DD_CCBB, 1'b1);
      issue(OP_LOAD,  3'b000, 32'h101,   32'h0,    5'd18, 1'b1, 32'h0,         3, 32'h0000_0056, 1'b1);

      mon_en = 1'b0;
      drive(OP_R, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("wb_queue_empty", 32'(wb_q.size()), 32'h0);
      chk("wr_queue_empty", 32'(wr_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
